fetch_seq_ctrl: RTL and testbench
=================================

Name: fetch_seq_ctrl

Overview:
- Sequences the pre-IF stage: generates the next fetch address and drives the instruction SRAM-like bus (req/addr_ok/data_ok).
- Feeds pre_pc, pre_exception_type, stall and flush into the PC pipeline register.
- Absorbs branch and exception redirects that arrive while a fetch is outstanding; stale instructions are discarded, never delivered.

Parameters:
- RESET_PC, 32'hBFC00000, first fetch address after reset
- EXC_ADEL_IF, 32'h00000004, pre_exception_type value for a misaligned fetch address

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- pipe_stall  in  1  downstream cannot accept an instruction this cycle
- branch_valid  in  1  branch redirect request, single-cycle pulse
- branch_target  in  32  branch redirect address
- exc_flush  in  1  exception/eret redirect and pipeline flush, single-cycle pulse
- exc_target  in  32  exception vector or EPC
- inst_req  out  1  bus request
- inst_addr  out  32  bus address, stable while inst_req=1 and addr_ok=0
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  data for the oldest accepted request returns this cycle
- pre_pc  out  32  PC of the delivered instruction
- pre_exception_type  out  32  fetch exception code; 0 or EXC_ADEL_IF
- pc_stall  out  1  1 = PC register must hold (no delivery this cycle)
- pc_flush  out  1  flush the PC register
- fetch_busy  out  1  state is WAIT or DISCARD

Behaviour:
- States: REQ, WAIT, HOLD, DISCARD, ERR.
- Registers: fetch_pc; pend_valid/pend_target (buffered redirect); hold_pc.
- Async reset (rst=0):
  - state=REQ, fetch_pc=RESET_PC, pend_valid=0.
  - Outputs: inst_req=0, pre_pc=0, pre_exception_type=0, pc_stall=1, pc_flush=0.
  - inst_req is forced 0 while rst=0. The first request is asserted in the first cycle after release.
- Redirect this cycle (redir): exc_flush or branch_valid.
  - Target: exc_target if exc_flush, else branch_target. Exception wins a simultaneous branch.
- pc_flush = exc_flush, combinational, same cycle.
- Pending buffer:
  - exc_flush overwrites a pending branch.
  - branch_valid does not overwrite a pending exception.
- REQ:
  - If fetch_pc[1:0]!=0: inst_req=0 and go to ERR.
  - Otherwise inst_req=1, inst_addr=fetch_pc.
  - Redirect while addr_ok=0: the address stays stable; the redirect is stored in pend.
  - On addr_ok: if redir or pend_valid, go DISCARD (pend updated); else go WAIT.
- WAIT (inst_req=0):
  - redir with data_ok=0: store in pend, go DISCARD.
  - data_ok and redir: drop the data, fetch_pc=target, go REQ, pc_stall=1.
  - data_ok and !pipe_stall: deliver; pre_pc=fetch_pc, exc_type=0, pc_stall=0; fetch_pc+=4; go REQ.
  - data_ok and pipe_stall: hold_pc=fetch_pc, go HOLD, pc_stall=1.
- HOLD:
  - pre_pc=hold_pc; pc_stall=pipe_stall.
  - On !pipe_stall: deliver, fetch_pc=hold_pc+4, go REQ.
  - redir (priority over delivery): pc_stall=1, fetch_pc=target, go REQ.
- DISCARD:
  - Wait for data_ok; pc_stall=1; the data is dropped.
  - Then fetch_pc=pend_target (or this cycle's redir target), pend_valid=0, go REQ.
  - A further redir updates pend per the priority rules.
- ERR:
  - pre_pc=fetch_pc, pre_exception_type=EXC_ADEL_IF, pc_stall=pipe_stall. Delivered once.
  - Then pc_stall=1 with no requests until redir: fetch_pc=target, go REQ.
- pc_stall=1 in every cycle not listed as a delivery.
- pre_pc and pre_exception_type are don't-care when pc_stall=1; drive the last value.
- PC arithmetic is modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
- At most one outstanding bus request.
- Redirect in the same cycle as delivery: delivery is suppressed, redirect taken.

Decomposition:
- Shared defines header: state encodings; EXC_ADEL_IF; RESET_PC; polarity constants, with `RST_ENABLE as 1'b0 for this block.
- One sub-module, redirect_buf: pend_valid/pend_target with exception-over-branch priority and clear-on-consume.

Test Plan:
- Reset release, addr_ok and data_ok each one cycle after request, pipe_stall=0 → inst_addr 0xBFC00000, 0xBFC00004, …; pc_stall=0 on each data_ok cycle; pre_pc matches.
- Branch to 0xBFC00100 while in WAIT; data_ok two cycles later → instruction at the old PC not delivered (pc_stall=1); next inst_addr=0xBFC00100.
- Same cycle: branch_valid (0x100) and exc_flush (0xBFC00380) during DISCARD, with a later branch to 0x200 → fetch resumes at 0xBFC00380; pc_flush=1 only in the exc_flush cycle.
- pipe_stall=1 for 3 cycles across data_ok at 0xBFC00008 → HOLD; pre_pc=0xBFC00008 delivered in the first cycle stall drops; next inst_addr=0xBFC0000C.
- Branch to 0x00400002 → no inst_req; pre_exception_type=0x4, pre_pc=0x00400002 delivered once; exc_flush to 0xBFC00380 → requests resume.
- rst asserted while in WAIT → outputs at reset values immediately; after release inst_addr=0xBFC00000.

Source files
------------

// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared constants and state encoding for the pre-IF fetch sequencer.
package fetch_seq_ctrl_pkg;

    localparam logic        RST_ENABLE       = 1'b0;
    localparam logic [31:0] RESET_PC_INIT    = 32'hBFC00000;
    localparam logic [31:0] EXC_ADEL_IF_CODE = 32'h00000004;

    typedef enum logic [2:0] {
        ST_REQ     = 3'd0,
        ST_WAIT    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_DISCARD = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_seq_ctrl_redirect_buf.sv
// Buffers a redirect that arrives while a fetch is in flight; an exception
// redirect may not be displaced by a later branch.
module redirect_buf
    import fetch_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        exc_flush,
    input  logic [31:0] exc_target,
    input  logic        load,
    input  logic        clear,
    output logic        merged_valid,
    output logic [31:0] merged_target
);

    logic        pend_valid;
    logic        pend_exc;
    logic [31:0] pend_target;
    logic        merged_exc;

    // merged_* is the pending entry with this cycle's redirect folded in
    always_comb begin
        merged_valid  = pend_valid | exc_flush | branch_valid;
        merged_exc    = pend_exc;
        merged_target = pend_target;
        if (exc_flush) begin
            merged_exc    = 1'b1;
            merged_target = exc_target;
        end else if (branch_valid && !(pend_valid && pend_exc)) begin
            merged_exc    = 1'b0;
            merged_target = branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            pend_valid  <= 1'b0;
            pend_exc    <= 1'b0;
            pend_target <= 32'd0;
        end else if (clear) begin
            pend_valid <= 1'b0;
            pend_exc   <= 1'b0;
        end else if (load) begin
            pend_valid  <= merged_valid;
            pend_exc    <= merged_exc;
            pend_target <= merged_target;
        end
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Pre-IF fetch sequencer: drives the instruction bus, delivers PCs to the
// PC register and absorbs redirects that race an outstanding fetch.
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_INIT,
    parameter logic [31:0] EXC_ADEL_IF = EXC_ADEL_IF_CODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        exc_flush,
    input  logic [31:0] exc_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic [31:0] pre_pc,
    output logic [31:0] pre_exception_type,
    output logic        pc_stall,
    output logic        pc_flush,
    output logic        fetch_busy
);

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] hold_pc;
    logic        err_done;
    logic [31:0] last_pc;
    logic [31:0] last_exc;

    logic        redir;
    logic [31:0] redir_target;
    logic        misaligned;
    logic        deliver;
    logic [31:0] cur_pc;
    logic [31:0] cur_exc;
    logic        pend_load;
    logic        pend_clear;
    logic        merged_valid;
    logic [31:0] merged_target;

    assign redir        = exc_flush | branch_valid;
    assign redir_target = exc_flush ? exc_target : branch_target;
    assign misaligned   = |fetch_pc[1:0];
    assign inst_addr    = fetch_pc;
    assign pc_flush     = exc_flush;
    assign fetch_busy   = (state == ST_WAIT) || (state == ST_DISCARD);

    // A redirect in the same cycle always suppresses delivery
    always_comb begin
        inst_req = (rst != RST_ENABLE) && (state == ST_REQ) && !misaligned;
        deliver  = 1'b0;
        cur_pc   = fetch_pc;
        cur_exc  = 32'd0;
        case (state)
            ST_WAIT: deliver = inst_data_ok && !redir && !pipe_stall;
            ST_HOLD: begin
                deliver = !pipe_stall && !redir;
                cur_pc  = hold_pc;
            end
            ST_ERR: begin
                deliver = !err_done && !pipe_stall && !redir;
                cur_exc = EXC_ADEL_IF;
            end
            default: deliver = 1'b0;
        endcase
        pc_stall           = !deliver;
        pre_pc             = deliver ? cur_pc : last_pc;
        pre_exception_type = deliver ? cur_exc : last_exc;
        pend_load  = ((state == ST_REQ) && !misaligned) ||
                     (((state == ST_WAIT) || (state == ST_DISCARD)) && !inst_data_ok);
        pend_clear = (state == ST_DISCARD) && inst_data_ok;
    end

    redirect_buf u_redirect_buf (
        .clk           (clk),
        .rst           (rst),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .exc_flush     (exc_flush),
        .exc_target    (exc_target),
        .load          (pend_load),
        .clear         (pend_clear),
        .merged_valid  (merged_valid),
        .merged_target (merged_target)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state    <= ST_REQ;
            fetch_pc <= RESET_PC;
            hold_pc  <= 32'd0;
            err_done <= 1'b0;
            last_pc  <= 32'd0;
            last_exc <= 32'd0;
        end else begin
            if (deliver) begin
                last_pc  <= cur_pc;
                last_exc <= cur_exc;
            end
            case (state)
                ST_REQ: begin
                    if (misaligned) begin
                        if (redir) begin
                            fetch_pc <= redir_target;
                        end else begin
                            state    <= ST_ERR;
                            err_done <= 1'b0;
                        end
                    end else if (inst_addr_ok) begin
                        state <= merged_valid ? ST_DISCARD : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        if (redir) begin
                            fetch_pc <= redir_target;
                            state    <= ST_REQ;
                        end else if (!pipe_stall) begin
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= ST_REQ;
                        end else begin
                            hold_pc <= fetch_pc;
                            state   <= ST_HOLD;
                        end
                    end else if (redir) begin
                        state <= ST_DISCARD;
                    end
                end
                ST_HOLD: begin
                    if (redir) begin
                        fetch_pc <= redir_target;
                        state    <= ST_REQ;
                    end else if (!pipe_stall) begin
                        fetch_pc <= hold_pc + 32'd4;
                        state    <= ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    if (inst_data_ok) begin
                        fetch_pc <= merged_target;
                        state    <= ST_REQ;
                    end
                end
                ST_ERR: begin
                    if (redir) begin
                        fetch_pc <= redir_target;
                        state    <= ST_REQ;
                    end else if (deliver) begin
                        err_done <= 1'b1;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed scenarios followed by a randomized bus/redirect run checked
// against an architectural next-PC model.
module tb_fetch_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        pipe_stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        exc_flush;
    logic [31:0] exc_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] pre_pc;
    logic [31:0] pre_exception_type;
    logic        pc_stall;
    logic        pc_flush;
    logic        fetch_busy;

    int checks = 0;
    int errors = 0;

    fetch_seq_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .pipe_stall         (pipe_stall),
        .branch_valid       (branch_valid),
        .branch_target      (branch_target),
        .exc_flush          (exc_flush),
        .exc_target         (exc_target),
        .inst_req           (inst_req),
        .inst_addr          (inst_addr),
        .inst_addr_ok       (inst_addr_ok),
        .inst_data_ok       (inst_data_ok),
        .pre_pc             (pre_pc),
        .pre_exception_type (pre_exception_type),
        .pc_stall           (pc_stall),
        .pc_flush           (pc_flush),
        .fetch_busy         (fetch_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then move to the sampling point (negedge)
    task automatic drive(input logic ps, input logic aok, input logic dok,
                         input logic br, input logic [31:0] bt,
                         input logic ex, input logic [31:0] et);
        pipe_stall    = ps;
        inst_addr_ok  = aok;
        inst_data_ok  = dok;
        branch_valid  = br;
        branch_target = bt;
        exc_flush     = ex;
        exc_target    = et;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [31:0] pc, input string tag);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk({tag, "_req"}, inst_req, 1);
        chk({tag, "_addr"}, inst_addr, pc);
        nxt();
        drive(0, 0, 1, 0, 0, 0, 0);
        chk({tag, "_stall"}, pc_stall, 0);
        chk({tag, "_pc"}, pre_pc, pc);
        chk({tag, "_exc"}, pre_exception_type, 0);
        nxt();
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom & 32'hFFFF_FFFC;
        if (($urandom % 10) == 0) t[1:0] = 2'b10;
        return t;
    endfunction

    initial begin
        logic        ps, aok, dok, br, ex;
        logic [31:0] bt, et, exp_pc, prev_addr;
        logic        exp_valid, block_br, prev_hold;
        int unsigned outstanding;
        int          delivered;

        rst = 1'b0;
        pipe_stall = 0; branch_valid = 0; branch_target = 0;
        exc_flush = 0; exc_target = 0; inst_addr_ok = 0; inst_data_ok = 0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_req", inst_req, 0);
        chk("rst_pre_pc", pre_pc, 0);
        chk("rst_exc", pre_exception_type, 0);
        chk("rst_stall", pc_stall, 1);
        chk("rst_flush", pc_flush, 0);
        chk("rst_busy", fetch_busy, 0);
        nxt();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rel_req", inst_req, 1);
        chk("rel_addr", inst_addr, 32'hBFC00000);
        nxt();

        // sequential fetch
        fetch_one(32'hBFC00000, "seq0");
        fetch_one(32'hBFC00004, "seq1");

        // pipe_stall across data_ok -> hold then deliver
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("hold_addr", inst_addr, 32'hBFC00008);
        nxt();
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("hold_s0", pc_stall, 1);
        nxt();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("hold_s1", pc_stall, 1);
        nxt();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("hold_s2", pc_stall, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("hold_dlv", pc_stall, 0);
        chk("hold_pc", pre_pc, 32'hBFC00008);
        nxt();

        // branch while in WAIT; stale data dropped
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("br_addr", inst_addr, 32'hBFC0000C);
        nxt();
        drive(0, 0, 0, 1, 32'hBFC00100, 0, 0);
        chk("br_stall", pc_stall, 1);
        chk("br_busy", fetch_busy, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("br_wait", pc_stall, 1);
        nxt();
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("br_drop", pc_stall, 1);
        nxt();
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("br_new_req", inst_req, 1);
        chk("br_new_addr", inst_addr, 32'hBFC00100);
        nxt();

        // exception beats branch in DISCARD; later branch cannot override
        drive(0, 0, 0, 1, 32'h00000300, 0, 0);
        chk("ex_enter", pc_stall, 1);
        nxt();
        drive(0, 0, 0, 1, 32'h00000100, 1, 32'hBFC00380);
        chk("ex_flush1", pc_flush, 1);
        chk("ex_stall", pc_stall, 1);
        nxt();
        drive(0, 0, 0, 1, 32'h00000200, 0, 0);
        chk("ex_flush0", pc_flush, 0);
        nxt();
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("ex_drop", pc_stall, 1);
        nxt();
        fetch_one(32'hBFC00380, "ex_resume");

        // redirect with data_ok to a misaligned target
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("mis_addr", inst_addr, 32'hBFC00384);
        nxt();
        drive(0, 0, 1, 1, 32'h00400002, 0, 0);
        chk("mis_suppr", pc_stall, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("mis_noreq", inst_req, 0);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("err_dlv", pc_stall, 0);
        chk("err_pc", pre_pc, 32'h00400002);
        chk("err_exc", pre_exception_type, 32'h4);
        chk("err_noreq", inst_req, 0);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("err_once", pc_stall, 1);
        chk("err_noreq2", inst_req, 0);
        nxt();
        drive(0, 0, 0, 0, 0, 1, 32'hBFC00380);
        chk("err_flush", pc_flush, 1);
        chk("err_redir", pc_stall, 1);
        nxt();
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("err_resume_req", inst_req, 1);
        chk("err_resume_addr", inst_addr, 32'hBFC00380);
        nxt();

        // asynchronous reset while in WAIT
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("arst_busy", fetch_busy, 1);
        rst = 1'b0;
        #1;
        chk("arst_req", inst_req, 0);
        chk("arst_stall", pc_stall, 1);
        chk("arst_pc", pre_pc, 0);
        chk("arst_exc", pre_exception_type, 0);
        chk("arst_busy0", fetch_busy, 0);
        nxt();
        rst = 1'b1;
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("arst_rel_req", inst_req, 1);
        chk("arst_rel_addr", inst_addr, 32'hBFC00000);
        nxt();

        // PC wrap at the top of the address space
        drive(0, 0, 1, 1, 32'hFFFFFFFC, 0, 0);
        chk("wrap_suppr", pc_stall, 1);
        nxt();
        fetch_one(32'hFFFFFFFC, "wrap");
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_req", inst_req, 1);
        chk("wrap_addr", inst_addr, 32'h00000000);

        // randomized run against an architectural next-PC model
        exp_pc = 32'h0; exp_valid = 1'b1; block_br = 1'b0;
        prev_hold = 1'b0; prev_addr = 32'h0; outstanding = 0; delivered = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            nxt();
            ps  = ($urandom % 4) == 0;
            aok = inst_req && (($urandom % 2) == 0);
            dok = (outstanding > 0) && (($urandom % 3) != 0);
            ex  = ($urandom % 20) == 0;
            br  = !block_br && (($urandom % 12) == 0);
            bt  = rand_tgt();
            et  = rand_tgt();
            drive(ps, aok, dok, br, bt, ex, et);
            if (prev_hold) begin
                chk("rnd_req_held", inst_req, 1);
                chk("rnd_addr_stable", inst_addr, prev_addr);
            end
            if (inst_req) begin
                chk("rnd_one_outstanding", outstanding, 0);
                chk("rnd_req_aligned", inst_addr[1:0], 0);
            end
            chk("rnd_flush", pc_flush, ex);
            if (ex || br) chk("rnd_redir_suppr", pc_stall, 1);
            if (!pc_stall) begin
                delivered++;
                chk("rnd_dlv_allowed", exp_valid, 1);
                chk("rnd_pc", pre_pc, exp_pc);
                chk("rnd_exc", pre_exception_type, (exp_pc[1:0] != 2'b00) ? 32'h4 : 32'h0);
                if (exp_pc[1:0] != 2'b00) exp_valid = 1'b0;
                else exp_pc = exp_pc + 32'd4;
                block_br = 1'b0;
            end
            if (ex) begin
                exp_pc = et; exp_valid = 1'b1; block_br = 1'b1;
            end else if (br) begin
                exp_pc = bt; exp_valid = 1'b1;
            end
            prev_hold = inst_req && !aok;
            prev_addr = inst_addr;
            outstanding = outstanding + ((inst_req && aok) ? 1 : 0) - (dok ? 1 : 0);
        end
        chk("rnd_progress", (delivered > 100) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
